// File: rtl/ex_mem_pkg.sv
// EX->MEM pipeline stage shared types: default widths, payload struct, bubble constant.
package ex_mem_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned REG_IDX_W_DEF = 5;
  localparam int unsigned DM_EN_W_DEF   = XLEN_DEF / 8;
  localparam int unsigned FUNC3_W_DEF   = 3;
  localparam int unsigned CNT_W_DEF     = 16;

  // One EX->MEM beat at the default widths
  typedef struct packed {
    logic [DM_EN_W_DEF-1:0]   dm_en;
    logic                     mux_rd;
    logic                     regfile_en;
    logic [FUNC3_W_DEF-1:0]   func3;
    logic [REG_IDX_W_DEF-1:0] rd_index;
    logic [XLEN_DEF-1:0]      alu_result;
    logic [XLEN_DEF-1:0]      write_data;
  } ex_mem_payload_t;

  localparam ex_mem_payload_t EX_MEM_BUBBLE = '0;

  // Flattened payload width for a given parameter set
  function automatic int unsigned payload_width(input int unsigned xlen,
                                                input int unsigned reg_idx_w,
                                                input int unsigned dm_en_w,
                                                input int unsigned func3_w);
    return dm_en_w + 2 + func3_w + reg_idx_w + 2 * xlen;
  endfunction

endpackage

// File: rtl/ex_mem_skid_buf.sv
// One-entry payload + valid holding register used as the EX->MEM skid slot.
module ex_mem_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned W = payload_width(XLEN_DEF, REG_IDX_W_DEF, DM_EN_W_DEF, FUNC3_W_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Next-state: load captures a beat, unload empties the slot
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM valid/ready pipeline stage with flush, forwarding tap and stall counter.
// Define EX_MEM_SKID_EN to add a one-entry skid slot (registered in_ready, capacity 2).
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned REG_IDX_W = REG_IDX_W_DEF,
  parameter int unsigned DM_EN_W   = XLEN / 8,
  parameter int unsigned FUNC3_W   = FUNC3_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DM_EN_W-1:0]   in_dm_en,
  input  logic                 in_mux_rd,
  input  logic                 in_regfile_en,
  input  logic [FUNC3_W-1:0]   in_func3,
  input  logic [REG_IDX_W-1:0] in_rd_index,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_write_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DM_EN_W-1:0]   out_dm_en,
  output logic                 out_mux_rd,
  output logic                 out_regfile_en,
  output logic [FUNC3_W-1:0]   out_func3,
  output logic [REG_IDX_W-1:0] out_rd_index,
  output logic [XLEN-1:0]      out_alu_result,
  output logic [XLEN-1:0]      out_write_data,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_rd_index,
  output logic [XLEN-1:0]      fwd_data,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned PW = payload_width(XLEN, REG_IDX_W, DM_EN_W, FUNC3_W);

  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] main_pl_q,   main_pl_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic          main_load_c;
  logic          accept_c;
  logic          src_valid_c;
  logic [PW-1:0] src_pl_c;
  logic [PW-1:0] in_pl_c;

  assign in_pl_c = {in_dm_en, in_mux_rd, in_regfile_en, in_func3,
                    in_rd_index, in_alu_result, in_write_data};

  // Main register advances whenever it is empty or MEM is consuming
  assign main_load_c = !out_valid_q || out_ready;

`ifdef EX_MEM_SKID_EN
  logic          skid_valid_c;
  logic [PW-1:0] skid_pl_c;
  logic          skid_load_c;
  logic          skid_unload_c;

  // in_ready comes straight from the skid valid flop
  assign in_ready      = !skid_valid_c;
  assign accept_c      = in_valid && !skid_valid_c && !flush;
  assign skid_load_c   = accept_c && out_valid_q && !out_ready;
  assign skid_unload_c = main_load_c && skid_valid_c;
  assign src_valid_c   = skid_valid_c || accept_c;
  assign src_pl_c      = skid_valid_c ? skid_pl_c : in_pl_c;

  ex_mem_skid_buf #(.W(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load_c),
    .unload (skid_unload_c),
    .din    (in_pl_c),
    .valid  (skid_valid_c),
    .dout   (skid_pl_c)
  );
`else
  assign in_ready    = !out_valid_q || out_ready;
  assign accept_c    = in_valid && in_ready && !flush;
  assign src_valid_c = accept_c;
  assign src_pl_c    = in_pl_c;
`endif

  // Main register next-state; bubbles clear write enables but keep data fields
  always_comb begin
    out_valid_d = out_valid_q;
    main_pl_d   = main_pl_q;
    if (main_load_c) begin
      out_valid_d = src_valid_c;
      if (src_valid_c) begin
        main_pl_d = src_pl_c;
      end else begin
        main_pl_d = {DM_EN_W'(0), out_mux_rd, 1'b0, out_func3,
                     out_rd_index, out_alu_result, out_write_data};
      end
    end
  end

  // Saturating count of cycles MEM holds off a valid beat
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      main_pl_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      main_pl_q   <= main_pl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign {out_dm_en, out_mux_rd, out_regfile_en, out_func3,
          out_rd_index, out_alu_result, out_write_data} = main_pl_q;
  assign stall_cnt = stall_cnt_q;

  // Forwarding tap: ALU results only, never loads or x0
  assign fwd_valid    = out_valid_q && out_regfile_en && !out_mux_rd && (out_rd_index != '0);
  assign fwd_rd_index = out_rd_index;
  assign fwd_data     = out_alu_result;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage with a reference queue scoreboard.
module tb_ex_mem_pipe_stage;
  import ex_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic in_valid;
  logic in_ready;
  ex_mem_payload_t in_pl;
  logic out_valid;
  logic out_ready;
  logic [DM_EN_W_DEF-1:0]   out_dm_en;
  logic                     out_mux_rd;
  logic                     out_regfile_en;
  logic [FUNC3_W_DEF-1:0]   out_func3;
  logic [REG_IDX_W_DEF-1:0] out_rd_index;
  logic [XLEN_DEF-1:0]      out_alu_result;
  logic [XLEN_DEF-1:0]      out_write_data;
  logic                     fwd_valid;
  logic [REG_IDX_W_DEF-1:0] fwd_rd_index;
  logic [XLEN_DEF-1:0]      fwd_data;
  logic [CNT_W_DEF-1:0]     stall_cnt;

  int checks = 0;
  int passes = 0;

  ex_mem_payload_t mq[$];
  logic [CNT_W_DEF-1:0] m_stall = '0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dm_en       (in_pl.dm_en),
    .in_mux_rd      (in_pl.mux_rd),
    .in_regfile_en  (in_pl.regfile_en),
    .in_func3       (in_pl.func3),
    .in_rd_index    (in_pl.rd_index),
    .in_alu_result  (in_pl.alu_result),
    .in_write_data  (in_pl.write_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_dm_en      (out_dm_en),
    .out_mux_rd     (out_mux_rd),
    .out_regfile_en (out_regfile_en),
    .out_func3      (out_func3),
    .out_rd_index   (out_rd_index),
    .out_alu_result (out_alu_result),
    .out_write_data (out_write_data),
    .fwd_valid      (fwd_valid),
    .fwd_rd_index   (fwd_rd_index),
    .fwd_data       (fwd_data),
    .stall_cnt      (stall_cnt)
  );

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // Model of in_ready given what the stage currently holds
  function automatic logic exp_ready();
`ifdef EX_MEM_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  function automatic ex_mem_payload_t out_pl();
    return {out_dm_en, out_mux_rd, out_regfile_en, out_func3,
            out_rd_index, out_alu_result, out_write_data};
  endfunction

  function automatic ex_mem_payload_t mk(input logic [3:0] dm, input logic mrd,
                                         input logic ren, input logic [4:0] rd,
                                         input logic [31:0] alu, input logic [31:0] wd);
    ex_mem_payload_t p;
    p = EX_MEM_BUBBLE;
    p.dm_en = dm; p.mux_rd = mrd; p.regfile_en = ren;
    p.func3 = 3'd2; p.rd_index = rd; p.alu_result = alu; p.write_data = wd;
    return p;
  endfunction

  // Advance one clock: update the scoreboard from the handshakes seen this cycle
  task automatic tick();
    logic acc, pop;
    acc = in_valid && exp_ready() && !flush;
    pop = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && (m_stall != '1)) m_stall = m_stall + 16'd1;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(in_pl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pl = EX_MEM_BUBBLE;
    #12;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else passes++;
    checks++; if (out_pl() !== EX_MEM_BUBBLE) $display("FAIL reset_payload got=%h exp=0", out_pl()); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_basic_fwd();
    out_ready = 1'b1; in_valid = 1'b1;
    in_pl = mk(4'h0, 1'b0, 1'b1, 5'd5, 32'h10, 32'h0);
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid got=%b exp=1", out_valid); else passes++;
    checks++; if (fwd_valid !== 1'b1) $display("FAIL basic_fwd_valid got=%b exp=1", fwd_valid); else passes++;
    checks++; if (fwd_rd_index !== 5'd5) $display("FAIL basic_fwd_rd got=%0d exp=5", fwd_rd_index); else passes++;
    checks++; if (fwd_data !== 32'h10) $display("FAIL basic_fwd_data got=%h exp=10", fwd_data); else passes++;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; flush = 1'b1;
    in_pl = mk(4'hF, 1'b0, 1'b1, 5'd9, 32'h100, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0; flush = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_dm_en !== 4'h0) $display("FAIL flush_dm_en got=%h exp=0", out_dm_en); else passes++;
    checks++; if (out_regfile_en !== 1'b0) $display("FAIL flush_regfile_en got=%b exp=0", out_regfile_en); else passes++;
  endtask

  task automatic test_no_fwd();
    out_ready = 1'b1; in_valid = 1'b1;
    in_pl = mk(4'h0, 1'b1, 1'b1, 5'd7, 32'h20, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL load_out_valid got=%b exp=1", out_valid); else passes++;
    checks++; if (fwd_valid !== 1'b0) $display("FAIL load_fwd_valid got=%b exp=0", fwd_valid); else passes++;
    in_pl = mk(4'h0, 1'b0, 1'b1, 5'd0, 32'h30, 32'h0);
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_regfile_en !== 1'b1) $display("FAIL x0_regfile_en got=%b exp=1", out_regfile_en); else passes++;
    checks++; if (fwd_valid !== 1'b0) $display("FAIL x0_fwd_valid got=%b exp=0", fwd_valid); else passes++;
    tick();
  endtask

  task automatic test_stall();
    ex_mem_payload_t seq[3];
    logic [CNT_W_DEF-1:0] base;
    int idx_in = 0;
    int idx_out = 0;
    seq[0] = mk(4'h1, 1'b0, 1'b1, 5'd1, 32'hA0, 32'hA1);
    seq[1] = mk(4'h2, 1'b0, 1'b1, 5'd2, 32'hB0, 32'hB1);
    seq[2] = mk(4'h4, 1'b0, 1'b1, 5'd3, 32'hC0, 32'hC1);
    base = m_stall;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (idx_in < 3);
      in_pl     = (idx_in < 3) ? seq[idx_in] : EX_MEM_BUBBLE;
      #1;
`ifdef EX_MEM_SKID_EN
      if (cyc == 1) begin
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_in_ready_c1 got=%b exp=1", in_ready); else passes++;
      end
`else
      if (cyc == 1) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_c1 got=%b exp=0", in_ready); else passes++;
      end
`endif
      if (cyc == 2 || cyc == 3) begin
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d got=%b exp=0", cyc, in_ready); else passes++;
      end
      if (cyc == 4) begin
        checks++;
        if (stall_cnt !== base + 16'd3) $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, base + 16'd3);
        else passes++;
      end
      if (out_valid && out_ready && idx_out < 3) begin
        checks++;
        if (out_pl() !== seq[idx_out]) $display("FAIL stall_order_%0d got=%h exp=%h", idx_out, out_pl(), seq[idx_out]);
        else passes++;
        idx_out++;
      end
      if (in_valid && exp_ready() && !flush) idx_in++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (idx_out !== 3) $display("FAIL stall_drain got=%0d exp=3", idx_out); else passes++;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10 && mq.size() < CAP; i++) begin
      in_valid = 1'b1;
      in_pl = mk(4'h8, 1'b0, 1'b1, 5'(10 + i), 32'h500 + 32'(i), 32'h0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL rststall_held got=%b exp=1", out_valid); else passes++;
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rststall_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (stall_cnt !== '0) $display("FAIL rststall_cnt got=%0d exp=0", stall_cnt); else passes++;
    mq.delete();
    m_stall = '0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL rststall_ghost_%0d got=%b exp=0", i, out_valid); else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    ex_mem_payload_t e;
    logic ev;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 9) == 0);
      in_pl.dm_en      = 4'($urandom);
      in_pl.mux_rd     = 1'($urandom);
      in_pl.regfile_en = 1'($urandom);
      in_pl.func3      = 3'($urandom);
      in_pl.rd_index   = 5'($urandom);
      in_pl.alu_result = $urandom;
      in_pl.write_data = $urandom;
      #1;
      checks++;
      if (in_ready !== exp_ready()) $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready());
      else passes++;
      checks++;
      if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() > 0);
      else passes++;
      if (mq.size() > 0) begin
        e = mq[0];
        ev = e.regfile_en && !e.mux_rd && (e.rd_index != 5'd0);
        checks++;
        if (out_pl() !== e) $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, out_pl(), e);
        else passes++;
        checks++;
        if (fwd_valid !== ev || (ev && (fwd_data !== e.alu_result || fwd_rd_index !== e.rd_index)))
          $display("FAIL rnd_fwd cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, fwd_valid, fwd_rd_index, fwd_data,
                   ev, e.rd_index, e.alu_result);
        else passes++;
      end else begin
        checks++;
        if (out_dm_en !== 4'h0 || out_regfile_en !== 1'b0 || fwd_valid !== 1'b0)
          $display("FAIL rnd_bubble cyc=%0d got dm_en=%h ren=%b fwd=%b exp 0/0/0", cyc, out_dm_en, out_regfile_en, fwd_valid);
        else passes++;
      end
      checks++;
      if (stall_cnt !== m_stall) $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall);
      else passes++;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rnd_final_drain got=%b exp=0", out_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic_fwd();
    test_flush();
    test_no_fwd();
    test_stall();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
